// File: rtl/beepboop_msg_rx.sv
// beepboop_msg_rx: MSB-first serial message receiver feeding a byte FIFO,
// with NUL-terminated framing, length limit and sticky error flags.
module beepboop_msg_rx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_LEN    = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic       rx_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       msg_done,
  output logic       frame_err,
  output logic       overflow,
  output logic [5:0] byte_count,
  input  logic       clr_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LEN_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             rx_valid_prev_q;
  logic             msg_done_q, msg_done_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic [5:0]       byte_count_q, byte_count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  logic [7:0]       rx_byte;
  logic [LEN_W-1:0] len_next;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             full;
  logic             frame_set;
  logic             ovf_set;

  // State and control registers; reset empties the FIFO and drops any partial byte
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      rx_valid_prev_q <= 1'b0;
      msg_done_q      <= 1'b0;
      frame_err_q     <= 1'b0;
      overflow_q      <= 1'b0;
      byte_count_q    <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_valid_prev_q <= rx_valid;
      msg_done_q      <= msg_done_d;
      frame_err_q     <= frame_err_d;
      overflow_q      <= overflow_d;
      byte_count_q    <= byte_count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
    end
  end

  // FIFO storage, written only when a completed byte is accepted
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= rx_byte;
    end
  end

  // Receive FSM next-state, FIFO bookkeeping and sticky flag update
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_count_d = byte_count_q;
    msg_done_d   = 1'b0;
    frame_set    = 1'b0;
    push_req     = 1'b0;
    rx_byte      = {shift_q, rx_bit};
    len_next     = LEN_W'(byte_count_q) + LEN_W'(1);

    case (state_q)
      IDLE: begin
        // only a fresh rising edge of rx_valid opens a message
        if (rx_valid && !rx_valid_prev_q) begin
          state_d      = RECV;
          shift_d      = {6'd0, rx_bit};
          bit_cnt_d    = 3'd1;
          byte_count_d = '0;
        end
      end
      RECV: begin
        if (!rx_valid) begin
          frame_set = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          shift_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte == 8'h00) begin
              msg_done_d = 1'b1;
              state_d    = DRAIN;
            end else if (32'(len_next) > MAX_LEN) begin
              frame_set = 1'b1;
              state_d   = DRAIN;
            end else begin
              push_req     = 1'b1;
              byte_count_d = (byte_count_q == 6'd63) ? byte_count_q : byte_count_q + 6'd1;
            end
          end
        end
      end
      DRAIN: begin
        if (!rx_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // pop happens before push, so a full FIFO that is also popping still accepts
    full     = (occ_q == CNT_W'(FIFO_DEPTH));
    pop      = (occ_q != '0) && byte_ready;
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q + CNT_W'(push) - CNT_W'(pop);

    // a flag being set outranks a simultaneous clear
    frame_err_d = frame_set ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    overflow_d  = ovf_set ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
  end

  assign byte_valid = (occ_q != '0);
  assign byte_out   = (occ_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign msg_done   = msg_done_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule

// File: doc/beepboop_msg_rx.md
BEEPBOOP_MSG_RX -- requirements
Module: beepboop_msg_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, giving the receive-byte FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter MAX_LEN, default 40, giving the maximum non-NUL bytes per message.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 rx_bit  input  1  serial data bit, MSB-first within each byte.
REQ-006 rx_valid  input  1  serial bit qualifier; high for the whole message frame.
REQ-007 byte_out  output  8  FIFO head byte.
REQ-008 byte_valid  output  1  FIFO non-empty.
REQ-009 byte_ready  input  1  consumer accepts head byte.
REQ-010 msg_done  output  1  one-cycle pulse on NUL terminator receipt.
REQ-011 frame_err  output  1  sticky framing error flag.
REQ-012 overflow  output  1  sticky FIFO overflow flag.
REQ-013 byte_count  output  6  non-NUL bytes received in current/last message, saturating at 63.
REQ-014 clr_err  input  1  clears frame_err and overflow.

Function
REQ-015 SHALL implement states IDLE, RECV, DRAIN.
REQ-016 IDLE: rx_valid sampled high when the previous sample was low -> RECV; that cycle's rx_bit is bit 7 of byte 0; byte_count cleared to 0.
REQ-017 RECV: each cycle with rx_valid=1 shifts rx_bit into a shift register and increments a 3-bit bit counter; 8th bit completes the byte.
REQ-018 Completed byte != 8'h00: pushed to FIFO, byte_count incremented (saturating), bit counter wraps to 0.
REQ-019 Completed byte == 8'h00: not pushed; msg_done=1 for exactly the following cycle; state -> DRAIN.
REQ-020 Completed non-NUL byte making the count exceed MAX_LEN: not pushed; frame_err set; -> DRAIN.
REQ-021 RECV with rx_valid=0: frame_err set, partial byte discarded, -> IDLE; applies both mid-byte (bit counter != 0) and at a byte boundary (no terminator).
REQ-022 DRAIN: ignores rx_bit; rx_valid=0 -> IDLE; frame_err not set by this exit.
REQ-023 Push latency: byte whose 8th bit is sampled at edge N is visible on byte_out/byte_valid after edge N.
REQ-024 Pop: byte_valid=1 and byte_ready=1 at an edge removes the head; byte_ready ignored when empty.
REQ-025 Full FIFO with simultaneous pop and push: pop then push; byte accepted, no overflow.
REQ-026 Full FIFO with push and no pop: byte dropped, overflow set, reception continues.
REQ-027 Empty FIFO: byte_out=8'h00, byte_valid=0.
REQ-028 FIFO order is strict FIFO; pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-029 Flag set and clr_err in the same cycle: set wins.
REQ-030 FIFO contents are not cleared at message start; bytes from a prior message remain until popped.

Reset
REQ-031 Reset SHALL force state IDLE, FIFO empty, byte_out=8'h00, byte_valid=0, msg_done=0, frame_err=0, overflow=0, byte_count=0, bit counter 0, and previous-rx_valid register 0.
REQ-032 Reset mid-message SHALL discard the partial byte and all FIFO contents; after release, rx_valid still high SHALL count as a rising edge and start a new message.
REQ-033 Reset SHALL take priority over all other inputs.

Verification
REQ-034 Send "Hi\0" (0x48,0x69,0x00) with byte_ready=1 -> pops 0x48, 0x69 in order; msg_done one pulse one cycle after the 24th bit; byte_count=2; no flags.
REQ-035 Drop rx_valid after 5 bits of byte 1 -> frame_err=1, FIFO receives only byte 0, state IDLE; clr_err -> frame_err=0.
REQ-036 byte_ready=0, send 9 non-NUL bytes + NUL -> 8 bytes held, overflow=1, byte_count=9; then pop 8 -> first 8 bytes in order.
REQ-037 FIFO full, byte_ready=1 held through the next byte completion -> no overflow, order preserved.
REQ-038 Send 41 non-NUL bytes -> 40 pushed, frame_err=1 on the 41st, msg_done never asserts; 42nd byte ignored until rx_valid falls.
REQ-039 Assert reset mid-byte with 3 bytes queued -> all outputs at reset values; a fresh "A\0" afterwards yields 0x41 only.
